fetch_stage: RTL and testbench

//  Instruction-fetch stage: owns the PC, drives instruction memory and fills the IF/ID pipeline register.

---
 rtl/fetch_stage_if.sv | 32 +++
 rtl/fetch_stage.sv | 154 +++++++++++++++
 tb/tb_fetch_stage.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage_if
// Description : Hazard-unit control, instruction-memory and IF/ID signals of
//               the instruction-fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_stage_if #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 16
);
    logic [1:0]         pc_src;
    logic [ADDR_W-1:0]  branch_target;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_data;
    logic [INSTR_W-1:0] if_id_instr;
    logic [INSTR_W-1:0] if_id_imm;
    logic [ADDR_W-1:0]  if_id_pc;
    logic               if_id_valid;
    logic [ADDR_W-1:0]  pc;

    modport master (
        input  pc_src, branch_target, imem_data,
        output imem_addr, if_id_instr, if_id_imm, if_id_pc, if_id_valid, pc
    );

    modport slave (
        output pc_src, branch_target, imem_data,
        input  imem_addr, if_id_instr, if_id_imm, if_id_pc, if_id_valid, pc
    );
endinterface
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction fetch - owns the PC, loads it from the reset
//               vector, assembles two-word instructions into IF/ID.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter int                ADDR_W       = 32,
    parameter int                INSTR_W      = 16,
    parameter logic [ADDR_W-1:0] RST_VEC_ADDR = '0
) (
    input  wire            clk,
    input  wire            rst,
    fetch_stage_if.master  bus
);

    localparam logic [1:0] c_st_vec_hi = 2'd0;
    localparam logic [1:0] c_st_vec_lo = 2'd1;
    localparam logic [1:0] c_st_run    = 2'd2;
    localparam logic [1:0] c_st_imm    = 2'd3;

    localparam logic [1:0] c_src_branch = 2'b01;
    localparam logic [1:0] c_src_hold   = 2'b10;

    localparam logic [ADDR_W-1:0] c_vec_lo_addr = RST_VEC_ADDR + ADDR_W'(1);

    logic [1:0]           r_state, w_state_nxt;
    logic [ADDR_W-1:0]    r_pc, w_pc_nxt;
    logic [INSTR_W-1:0]   r_instr, w_instr_nxt;
    logic [INSTR_W-1:0]   r_imm, w_imm_nxt;
    logic [ADDR_W-1:0]    r_if_pc, w_if_pc_nxt;
    logic                 r_valid, w_valid_nxt;
    logic [INSTR_W-1:0]   r_vec_hi, w_vec_hi_nxt;
    logic [INSTR_W-1:0]   r_hold_word, w_hold_word_nxt;
    logic [ADDR_W-1:0]    r_hold_pc, w_hold_pc_nxt;
    logic [ADDR_W-1:0]    w_imem_addr;
    logic [ADDR_W-1:0]    w_pc_inc;
    logic [2*INSTR_W-1:0] w_vec_full;

    assign w_pc_inc   = r_pc + ADDR_W'(1);
    assign w_vec_full = {r_vec_hi, bus.imem_data};

    always_ff @(posedge clk) begin
        if (rst) r_state <= c_st_vec_hi;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = c_st_vec_hi;
        case (r_state)
            c_st_vec_hi: w_state_nxt = c_st_vec_lo;
            c_st_vec_lo: w_state_nxt = c_st_run;
            c_st_run: begin
                w_state_nxt = c_st_run;
                if (bus.pc_src != c_src_hold && bus.pc_src != c_src_branch && bus.imem_data[0])
                    w_state_nxt = c_st_imm;
            end
            c_st_imm:    w_state_nxt = (bus.pc_src == c_src_hold) ? c_st_imm : c_st_run;
            default:     w_state_nxt = c_st_vec_hi;
        endcase
    end

    always_comb begin
        w_imem_addr     = r_pc;
        w_pc_nxt        = r_pc;
        w_instr_nxt     = r_instr;
        w_imm_nxt       = r_imm;
        w_if_pc_nxt     = r_if_pc;
        w_valid_nxt     = r_valid;
        w_vec_hi_nxt    = r_vec_hi;
        w_hold_word_nxt = r_hold_word;
        w_hold_pc_nxt   = r_hold_pc;
        case (r_state)
            c_st_vec_hi: begin
                w_imem_addr  = RST_VEC_ADDR;
                w_vec_hi_nxt = bus.imem_data;
            end
            c_st_vec_lo: begin
                w_imem_addr = c_vec_lo_addr;
                w_pc_nxt    = w_vec_full[ADDR_W-1:0];
                w_valid_nxt = 1'b0;
            end
            c_st_run: begin
                if (bus.pc_src == c_src_branch) begin
                    w_pc_nxt    = bus.branch_target;
                    w_instr_nxt = '0;
                    w_imm_nxt   = '0;
                    w_valid_nxt = 1'b0;
                end else if (bus.pc_src != c_src_hold) begin
                    w_pc_nxt = w_pc_inc;
                    if (bus.imem_data[0]) begin
                        // First half of a two-word instruction: park it, bubble IF/ID
                        w_hold_word_nxt = bus.imem_data;
                        w_hold_pc_nxt   = r_pc;
                        w_instr_nxt     = '0;
                        w_valid_nxt     = 1'b0;
                    end else begin
                        w_instr_nxt = bus.imem_data;
                        w_imm_nxt   = '0;
                        w_if_pc_nxt = r_pc;
                        w_valid_nxt = 1'b1;
                    end
                end
            end
            c_st_imm: begin
                if (bus.pc_src == c_src_branch) begin
                    w_pc_nxt    = bus.branch_target;
                    w_instr_nxt = '0;
                    w_imm_nxt   = '0;
                    w_valid_nxt = 1'b0;
                end else if (bus.pc_src != c_src_hold) begin
                    w_instr_nxt = r_hold_word;
                    w_imm_nxt   = bus.imem_data;
                    w_if_pc_nxt = r_hold_pc;
                    w_valid_nxt = 1'b1;
                    w_pc_nxt    = w_pc_inc;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc        <= '0;
            r_instr     <= '0;
            r_imm       <= '0;
            r_if_pc     <= '0;
            r_valid     <= 1'b0;
            r_vec_hi    <= '0;
            r_hold_word <= '0;
            r_hold_pc   <= '0;
        end else begin
            r_pc        <= w_pc_nxt;
            r_instr     <= w_instr_nxt;
            r_imm       <= w_imm_nxt;
            r_if_pc     <= w_if_pc_nxt;
            r_valid     <= w_valid_nxt;
            r_vec_hi    <= w_vec_hi_nxt;
            r_hold_word <= w_hold_word_nxt;
            r_hold_pc   <= w_hold_pc_nxt;
        end
    end

    assign bus.imem_addr   = w_imem_addr;
    assign bus.if_id_instr = r_instr;
    assign bus.if_id_imm   = r_imm;
    assign bus.if_id_pc    = r_if_pc;
    assign bus.if_id_valid = r_valid;
    assign bus.pc          = r_pc;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Directed testbench for fetch_stage with a small async imem.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] mem [0:255];
    int          n_checks = 0;
    int          n_fail   = 0;

    fetch_stage_if #(.ADDR_W(32), .INSTR_W(16)) bus ();

    fetch_stage #(.ADDR_W(32), .INSTR_W(16), .RST_VEC_ADDR(32'h0)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.imem_data = mem[bus.imem_addr[7:0]];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic [15:0] instr,
                              input logic [15:0] imm, input logic [31:0] ipc,
                              input logic valid, input logic [31:0] npc);
        check({tag, ".instr"}, {16'h0, bus.if_id_instr}, {16'h0, instr});
        check({tag, ".imm"},   {16'h0, bus.if_id_imm},   {16'h0, imm});
        check({tag, ".if_pc"}, bus.if_id_pc, ipc);
        check({tag, ".valid"}, {31'h0, bus.if_id_valid}, {31'h0, valid});
        check({tag, ".pc"},    bus.pc, npc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0;
        mem[8'h00] = 16'h0000;
        mem[8'h01] = 16'h0040;
        mem[8'h40] = 16'h1000;
        mem[8'h41] = 16'h2000;
        mem[8'h42] = 16'h3001;
        mem[8'h43] = 16'hBEEF;
        mem[8'h44] = 16'h5000;
        mem[8'h45] = 16'h7001;
        mem[8'h46] = 16'h1111;
        mem[8'h80] = 16'h6000;
        mem[8'h90] = 16'h7001;
        rst = 1'b1;
        bus.pc_src = 2'b00;
        bus.branch_target = 32'h0;

        // Reset vector fetch
        step();
        check("rst.addr", bus.imem_addr, 32'h0);
        check_ifid("rst", 16'h0, 16'h0, 32'h0, 1'b0, 32'h0);
        rst = 1'b0;
        step();
        check("vec_lo.addr", bus.imem_addr, 32'h1);
        check("vec_lo.valid", {31'h0, bus.if_id_valid}, 32'h0);
        step();
        check("vec.pc", bus.pc, 32'h40);
        check("vec.addr", bus.imem_addr, 32'h40);
        check("vec.valid", {31'h0, bus.if_id_valid}, 32'h0);

        // Sequential one-word fetches
        step();
        check_ifid("seq0", 16'h1000, 16'h0, 32'h40, 1'b1, 32'h41);
        step();
        check_ifid("seq1", 16'h2000, 16'h0, 32'h41, 1'b1, 32'h42);

        // Two-word at 0x42, stalled 3 cycles in the immediate state
        step();
        check("tw.bubble.valid", {31'h0, bus.if_id_valid}, 32'h0);
        check("tw.bubble.instr", {16'h0, bus.if_id_instr}, 32'h0);
        check("tw.bubble.pc", bus.pc, 32'h43);
        bus.pc_src = 2'b10;
        for (int i = 0; i < 3; i++) step();
        check("stall_imm.pc", bus.pc, 32'h43);
        check("stall_imm.valid", {31'h0, bus.if_id_valid}, 32'h0);
        check("stall_imm.addr", bus.imem_addr, 32'h43);
        bus.pc_src = 2'b11;
        step();
        check_ifid("tw", 16'h3001, 16'hBEEF, 32'h42, 1'b1, 32'h44);

        // Stall in the run state
        bus.pc_src = 2'b10;
        for (int i = 0; i < 3; i++) step();
        check_ifid("stall_run", 16'h3001, 16'hBEEF, 32'h42, 1'b1, 32'h44);
        bus.pc_src = 2'b00;
        step();
        check_ifid("after_stall", 16'h5000, 16'h0, 32'h44, 1'b1, 32'h45);

        // Branch flush while waiting for the immediate word
        step();
        check("br_imm.pre_pc", bus.pc, 32'h46);
        bus.pc_src = 2'b01;
        bus.branch_target = 32'h80;
        step();
        check_ifid("br_imm", 16'h0, 16'h0, 32'h44, 1'b0, 32'h80);
        bus.pc_src = 2'b00;
        step();
        check_ifid("after_br", 16'h6000, 16'h0, 32'h80, 1'b1, 32'h81);

        // Branch from the run state
        bus.pc_src = 2'b01;
        bus.branch_target = 32'h90;
        step();
        check_ifid("br_run", 16'h0, 16'h0, 32'h80, 1'b0, 32'h90);
        bus.pc_src = 2'b00;

        // Reset in the immediate state restarts the vector sequence
        step();
        check("pre_rst.pc", bus.pc, 32'h91);
        mem[8'h40] = 16'h3001;
        mem[8'h41] = 16'hBEEF;
        rst = 1'b1;
        step();
        check_ifid("mid_rst", 16'h0, 16'h0, 32'h0, 1'b0, 32'h0);
        check("mid_rst.addr", bus.imem_addr, 32'h0);
        rst = 1'b0;
        step();
        check("rerun.addr", bus.imem_addr, 32'h1);
        step();
        check("rerun.pc", bus.pc, 32'h40);
        step();
        check("tw40.bubble.valid", {31'h0, bus.if_id_valid}, 32'h0);
        check("tw40.bubble.pc", bus.pc, 32'h41);
        step();
        check_ifid("tw40", 16'h3001, 16'hBEEF, 32'h40, 1'b1, 32'h42);

        // PC wrap from all-ones
        mem[8'h00] = 16'hFFFF;
        mem[8'h01] = 16'hFFFF;
        mem[8'hFF] = 16'h1234;
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        step();
        check("wrap.pre_pc", bus.pc, 32'hFFFF_FFFF);
        step();
        check_ifid("wrap", 16'h1234, 16'h0, 32'hFFFF_FFFF, 1'b1, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
